// File: rtl/axis_reg_slice.sv
// AXI4-Stream register slice: bypass, one-entry buffer, or skid buffer.
// Breaks the timing paths between an upstream master and a downstream slave.
// The mode is chosen by REG_TYPE. Sideband fields whose *_ENABLE is 0 are
// driven as fixed constants on the output.
module axis_reg_slice #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
    parameter int LAST_ENABLE = 1,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int REG_TYPE    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    // All fields of one beat, kept together so they can never get separated.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    beat_t in_beat;
    beat_t out_beat;
    logic  out_valid;

    assign in_beat = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast,
                       id: s_axis_tid, dest: s_axis_tdest, user: s_axis_tuser};

    // Disabled sideband fields are constants, independent of the stored beat.
    assign m_axis_tdata  = out_beat.data;
    assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? out_beat.keep : {KEEP_WIDTH{1'b1}};
    assign m_axis_tlast  = (LAST_ENABLE != 0) ? out_beat.last : 1'b1;
    assign m_axis_tid    = (ID_ENABLE   != 0) ? out_beat.id   : '0;
    assign m_axis_tdest  = (DEST_ENABLE != 0) ? out_beat.dest : '0;
    assign m_axis_tuser  = (USER_ENABLE != 0) ? out_beat.user : '0;
    assign m_axis_tvalid = out_valid;

    if (REG_TYPE == 2) begin : g_skid
        logic  ready_reg;
        logic  out_valid_reg;
        logic  temp_valid_reg;
        logic  ready_early;
        logic  out_valid_next;
        logic  temp_valid_next;
        logic  load_out_from_in;
        logic  load_out_from_temp;
        logic  load_temp;
        beat_t out_reg;
        beat_t temp_reg;

        // Ready for the next cycle: m_axis_tready only reaches a register, never the port.
        assign ready_early = m_axis_tready ||
                             (!temp_valid_reg && (!out_valid_reg || !s_axis_tvalid));

        // Steer an accepted beat to the output or the skid register, and refill from skid.
        always_comb begin
            // NOTE: every signal gets a default first, so no path leaves one unassigned
            // and no latch is inferred.
            out_valid_next     = out_valid_reg;
            temp_valid_next    = temp_valid_reg;
            load_out_from_in   = 1'b0;
            load_out_from_temp = 1'b0;
            load_temp          = 1'b0;
            if (ready_reg) begin
                if (m_axis_tready || !out_valid_reg) begin
                    out_valid_next   = s_axis_tvalid;
                    load_out_from_in = s_axis_tvalid;
                end else begin
                    temp_valid_next = s_axis_tvalid;
                    load_temp       = s_axis_tvalid;
                end
            end else if (m_axis_tready) begin
                out_valid_next     = temp_valid_reg;
                temp_valid_next    = 1'b0;
                load_out_from_temp = temp_valid_reg;
            end
        end

        // Control state: the only registers that need reset.
        always_ff @(posedge clk) begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            if (!rst) begin
                ready_reg      <= 1'b0;
                out_valid_reg  <= 1'b0;
                temp_valid_reg <= 1'b0;
            end else begin
                ready_reg      <= ready_early;
                out_valid_reg  <= out_valid_next;
                temp_valid_reg <= temp_valid_next;
            end
        end

        // Payload registers, loaded only when a beat moves into them.
        always_ff @(posedge clk) begin
            // NOTE: payload is not reset; the valid flags make its contents don't-care.
            if (load_out_from_in) begin
                out_reg <= in_beat;
            end else if (load_out_from_temp) begin
                out_reg <= temp_reg;
            end
            if (load_temp) begin
                temp_reg <= in_beat;
            end
        end

        assign s_axis_tready = ready_reg;
        assign out_valid     = out_valid_reg;
        assign out_beat      = out_reg;
    end else if (REG_TYPE == 1) begin : g_simple
        logic  ready_reg;
        logic  out_valid_reg;
        logic  out_valid_next;
        logic  load_out;
        beat_t out_reg;

        // Accept again only once the output register will be empty.
        always_comb begin
            out_valid_next = out_valid_reg;
            load_out       = 1'b0;
            if (ready_reg) begin
                out_valid_next = s_axis_tvalid;
                load_out       = s_axis_tvalid;
            end else if (m_axis_tready) begin
                out_valid_next = 1'b0;
            end
        end

        // Control state with synchronous reset.
        always_ff @(posedge clk) begin
            if (!rst) begin
                ready_reg     <= 1'b0;
                out_valid_reg <= 1'b0;
            end else begin
                ready_reg     <= !out_valid_next;
                out_valid_reg <= out_valid_next;
            end
        end

        // Payload register.
        always_ff @(posedge clk) begin
            if (load_out) begin
                out_reg <= in_beat;
            end
        end

        assign s_axis_tready = ready_reg;
        assign out_valid     = out_valid_reg;
        assign out_beat      = out_reg;
    end else begin : g_bypass
        assign s_axis_tready = m_axis_tready;
        assign out_valid     = s_axis_tvalid;
        assign out_beat      = in_beat;
    end

endmodule

// File: tb/tb_axis_reg_slice.sv
// Directed testbench for axis_reg_slice: skid, simple, bypass and sideband
// configurations, with a small in-order scoreboard on the registered modes.
module tb_axis_reg_slice;

    logic clk;
    logic rst;
    logic m_ready;

    // Shared 8-bit stimulus
    logic [7:0] s_data;
    logic [0:0] s_keep;
    logic       s_valid;
    logic       s_last;
    logic [7:0] s_id;
    logic [7:0] s_dest;
    logic [0:0] s_user;

    // Shared 16-bit stimulus
    logic [15:0] w_data;
    logic [1:0]  w_keep;
    logic        w_valid;
    logic        w_last;
    logic [7:0]  w_id;
    logic [7:0]  w_dest;
    logic [0:0]  w_user;

    logic       skid_s_ready, skid_m_valid, skid_m_last;
    logic [7:0] skid_m_data, skid_m_id, skid_m_dest;
    logic [0:0] skid_m_keep, skid_m_user;

    logic       simp_s_ready, simp_m_valid, simp_m_last;
    logic [7:0] simp_m_data, simp_m_id, simp_m_dest;
    logic [0:0] simp_m_keep, simp_m_user;

    logic       byp_s_ready, byp_m_valid, byp_m_last;
    logic [7:0] byp_m_data, byp_m_id, byp_m_dest;
    logic [0:0] byp_m_keep, byp_m_user;

    logic        wide_s_ready, wide_m_valid, wide_m_last;
    logic [15:0] wide_m_data;
    logic [1:0]  wide_m_keep;
    logic [7:0]  wide_m_id, wide_m_dest;
    logic [0:0]  wide_m_user;

    logic        wnk_s_ready, wnk_m_valid, wnk_m_last;
    logic [15:0] wnk_m_data;
    logic [1:0]  wnk_m_keep;
    logic [7:0]  wnk_m_id, wnk_m_dest;
    logic [0:0]  wnk_m_user;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] skid_q[$];
    logic [7:0] simp_q[$];

    axis_reg_slice #(.REG_TYPE(2)) u_skid (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tready(skid_s_ready), .s_axis_tlast(s_last), .s_axis_tid(s_id),
        .s_axis_tdest(s_dest), .s_axis_tuser(s_user),
        .m_axis_tdata(skid_m_data), .m_axis_tkeep(skid_m_keep), .m_axis_tvalid(skid_m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(skid_m_last), .m_axis_tid(skid_m_id),
        .m_axis_tdest(skid_m_dest), .m_axis_tuser(skid_m_user)
    );

    axis_reg_slice #(.REG_TYPE(1)) u_simple (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tready(simp_s_ready), .s_axis_tlast(s_last), .s_axis_tid(s_id),
        .s_axis_tdest(s_dest), .s_axis_tuser(s_user),
        .m_axis_tdata(simp_m_data), .m_axis_tkeep(simp_m_keep), .m_axis_tvalid(simp_m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(simp_m_last), .m_axis_tid(simp_m_id),
        .m_axis_tdest(simp_m_dest), .m_axis_tuser(simp_m_user)
    );

    axis_reg_slice #(.REG_TYPE(0)) u_bypass (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tready(byp_s_ready), .s_axis_tlast(s_last), .s_axis_tid(s_id),
        .s_axis_tdest(s_dest), .s_axis_tuser(s_user),
        .m_axis_tdata(byp_m_data), .m_axis_tkeep(byp_m_keep), .m_axis_tvalid(byp_m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(byp_m_last), .m_axis_tid(byp_m_id),
        .m_axis_tdest(byp_m_dest), .m_axis_tuser(byp_m_user)
    );

    axis_reg_slice #(.DATA_WIDTH(16), .ID_ENABLE(1), .REG_TYPE(2)) u_wide (
        .clk(clk), .rst(rst),
        .s_axis_tdata(w_data), .s_axis_tkeep(w_keep), .s_axis_tvalid(w_valid),
        .s_axis_tready(wide_s_ready), .s_axis_tlast(w_last), .s_axis_tid(w_id),
        .s_axis_tdest(w_dest), .s_axis_tuser(w_user),
        .m_axis_tdata(wide_m_data), .m_axis_tkeep(wide_m_keep), .m_axis_tvalid(wide_m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(wide_m_last), .m_axis_tid(wide_m_id),
        .m_axis_tdest(wide_m_dest), .m_axis_tuser(wide_m_user)
    );

    axis_reg_slice #(.DATA_WIDTH(16), .KEEP_ENABLE(0), .ID_ENABLE(1), .REG_TYPE(2)) u_wide_nokeep (
        .clk(clk), .rst(rst),
        .s_axis_tdata(w_data), .s_axis_tkeep(w_keep), .s_axis_tvalid(w_valid),
        .s_axis_tready(wnk_s_ready), .s_axis_tlast(w_last), .s_axis_tid(w_id),
        .s_axis_tdest(w_dest), .s_axis_tuser(w_user),
        .m_axis_tdata(wnk_m_data), .m_axis_tkeep(wnk_m_keep), .m_axis_tvalid(wnk_m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(wnk_m_last), .m_axis_tid(wnk_m_id),
        .m_axis_tdest(wnk_m_dest), .m_axis_tuser(wnk_m_user)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        s_valid = 1'b0;
        w_valid = 1'b0;
        m_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // One skid-mode cycle: drive inputs, take the edge, compare with hand-computed values.
    task automatic skid_vec(input string tag, input logic v, input logic [7:0] d, input logic mr,
                            input logic exp_rdy, input logic exp_mv, input logic [7:0] exp_d);
        s_valid = v;
        s_data  = d;
        m_ready = mr;
        step();
        check($sformatf("%s_rdy", tag), skid_s_ready, exp_rdy);
        check($sformatf("%s_mv", tag), skid_m_valid, exp_mv);
        if (exp_mv) check($sformatf("%s_data", tag), skid_m_data, exp_d);
    endtask

    // In-order scoreboard for the two registered 8-bit instances.
    always @(negedge clk) begin
        if (!rst) begin
            skid_q.delete();
            simp_q.delete();
        end else begin
            if (skid_m_valid && m_ready) begin
                if (skid_q.size() == 0) check("skid_stale", skid_m_valid, 1'b0);
                else check("skid_order", skid_m_data, skid_q.pop_front());
            end
            if (s_valid && skid_s_ready) skid_q.push_back(s_data);
            if (simp_m_valid && m_ready) begin
                if (simp_q.size() == 0) check("simp_stale", simp_m_valid, 1'b0);
                else check("simp_order", simp_m_data, simp_q.pop_front());
            end
            if (s_valid && simp_s_ready) simp_q.push_back(s_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        m_ready = 1'b1;
        s_data  = '0; s_keep = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        s_id    = '0; s_dest = '0;   s_user  = '0;
        w_data  = '0; w_keep = '0;   w_valid = 1'b0; w_last = 1'b0;
        w_id    = '0; w_dest = '0;   w_user  = '0;

        // Reset then idle
        step();
        step();
        check("rst_skid_rdy", skid_s_ready, 1'b0);
        check("rst_skid_mv", skid_m_valid, 1'b0);
        check("rst_simp_rdy", simp_s_ready, 1'b0);
        check("rst_simp_mv", simp_m_valid, 1'b0);
        rst = 1'b1;
        step();
        check("idle_skid_rdy", skid_s_ready, 1'b1);
        check("idle_simp_rdy", simp_s_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("idle_skid_mv%0d", i), skid_m_valid, 1'b0);
            check($sformatf("idle_simp_mv%0d", i), simp_m_valid, 1'b0);
        end

        // Skid streaming: back-to-back 0x01..0x10, each beat visible one edge later
        do_reset();
        for (int c = 0; c < 16; c++) begin
            skid_vec($sformatf("stream%0d", c), 1'b1, 8'(c + 1), 1'b1, 1'b1, 1'b1, 8'(c + 1));
        end
        skid_vec("stream_end", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);

        // Skid backpressure: three stall cycles, two beats held (0x42 out, 0x43 skid)
        do_reset();
        skid_vec("bp0", 1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 8'h41);
        skid_vec("bp1", 1'b1, 8'h42, 1'b1, 1'b1, 1'b1, 8'h42);
        skid_vec("bp2", 1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 8'h42);
        skid_vec("bp3", 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h42);
        skid_vec("bp4", 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h42);
        skid_vec("bp5", 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h43);
        skid_vec("bp6", 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44);
        skid_vec("bp7", 1'b1, 8'h45, 1'b1, 1'b1, 1'b1, 8'h45);
        skid_vec("bp8", 1'b0, 8'h45, 1'b1, 1'b1, 1'b0, 8'h00);

        // Simple buffer: eight beats 0x31..0x38, one accepted every other cycle
        do_reset();
        for (int c = 0; c < 16; c++) begin
            s_valid = 1'b1;
            s_data  = 8'h31 + 8'(c / 2);
            m_ready = 1'b1;
            step();
            check($sformatf("simp%0d_mv", c), simp_m_valid, (c % 2) == 0);
            check($sformatf("simp%0d_rdy", c), simp_s_ready, (c % 2) == 1);
            if ((c % 2) == 0) check($sformatf("simp%0d_data", c), simp_m_data, 8'h31 + 8'(c / 2));
        end
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Bypass: outputs follow inputs within the same cycle
        for (int i = 0; i < 10; i++) begin
            s_data  = 8'($urandom);
            s_valid = 1'($urandom);
            s_last  = 1'($urandom);
            s_user  = 1'($urandom);
            s_id    = 8'($urandom);
            m_ready = 1'($urandom);
            #1;
            check($sformatf("byp%0d_data", i), byp_m_data, s_data);
            check($sformatf("byp%0d_valid", i), byp_m_valid, s_valid);
            check($sformatf("byp%0d_last", i), byp_m_last, s_last);
            check($sformatf("byp%0d_user", i), byp_m_user, s_user);
            check($sformatf("byp%0d_rdy", i), byp_s_ready, m_ready);
            check($sformatf("byp%0d_keep", i), byp_m_keep, 1'b1);
            check($sformatf("byp%0d_id", i), byp_m_id, 8'h00);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Sideband pass-through on 16-bit instances
        do_reset();
        w_valid = 1'b1;
        w_data  = 16'hBEEF;
        w_keep  = 2'b01;
        w_last  = 1'b1;
        w_id    = 8'h5A;
        w_dest  = 8'h33;
        w_user  = 1'b1;
        m_ready = 1'b1;
        step();
        w_valid = 1'b0;
        check("wide_mv", wide_m_valid, 1'b1);
        check("wide_data", wide_m_data, 16'hBEEF);
        check("wide_keep", wide_m_keep, 2'b01);
        check("wide_last", wide_m_last, 1'b1);
        check("wide_id", wide_m_id, 8'h5A);
        check("wide_dest", wide_m_dest, 8'h00);
        check("wide_user", wide_m_user, 1'b1);
        check("wnk_keep", wnk_m_keep, 2'b11);
        check("wnk_id", wnk_m_id, 8'h5A);
        step();
        check("wide_done_mv", wide_m_valid, 1'b0);

        // Reset with two beats buffered discards them
        do_reset();
        skid_vec("rst_a", 1'b1, 8'h51, 1'b0, 1'b1, 1'b1, 8'h51);
        skid_vec("rst_b", 1'b1, 8'h52, 1'b0, 1'b0, 1'b1, 8'h51);
        rst     = 1'b0;
        s_valid = 1'b0;
        step();
        check("midrst_mv", skid_m_valid, 1'b0);
        check("midrst_rdy", skid_s_ready, 1'b0);
        rst     = 1'b1;
        m_ready = 1'b1;
        step();
        check("postrst_rdy", skid_s_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("postrst_mv%0d", i), skid_m_valid, 1'b0);
            step();
        end

        check("skid_sb_drained", skid_q.size(), 0);
        check("simp_sb_drained", simp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_reg_slice.md
Name: axis_reg_slice

Overview:
- Single-channel AXI4-Stream register slice that breaks timing paths between an upstream master and a downstream slave.
- Selectable mode: combinational bypass, simple one-entry buffer, or full-throughput skid buffer.
- Used as the input and output pipeline stage of per-channel datapaths such as the LUT-based activation units.

Parameters:
- DATA_WIDTH, 8, tdata width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep when 1.
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width.
- LAST_ENABLE, 1, propagate tlast when 1.
- ID_ENABLE, 0, propagate tid when 1.
- ID_WIDTH, 8, tid width.
- DEST_ENABLE, 0, propagate tdest when 1.
- DEST_WIDTH, 8, tdest width.
- USER_ENABLE, 1, propagate tuser when 1.
- USER_WIDTH, 1, tuser width.
- REG_TYPE, 2, register mode: 0 = bypass, 1 = simple buffer, 2 = skid buffer.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  input byte qualifiers.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tid  in  ID_WIDTH  input stream id.
- s_axis_tdest  in  DEST_WIDTH  input routing.
- s_axis_tuser  in  USER_WIDTH  input sideband.
- m_axis_tdata / tkeep / tvalid / tlast / tid / tdest / tuser  out  same widths  output channel.
- m_axis_tready  in  1  output ready.

Behaviour:
- Transfer occurs on a rising edge where tvalid and tready are both 1.
- Beats are never dropped, duplicated or reordered; all fields of one beat travel together.
- Disabled fields are driven as constants at the output:
  - tkeep all ones.
  - tlast 1.
  - tid, tdest and tuser 0.
- REG_TYPE 0 (bypass):
  - All m_* outputs equal the corresponding s_* inputs combinationally.
  - s_axis_tready = m_axis_tready.
  - No state; reset has no effect.
- REG_TYPE 1 (simple buffer):
  - One output register; s_axis_tready is a registered signal.
  - s_axis_tready is 1 only when the output register will be empty in the next cycle.
  - Latency 1 cycle; maximum throughput 1 beat every 2 cycles.
  - No combinational path from any input to any output.
- REG_TYPE 2 (skid buffer):
  - Output register plus one temporary (skid) register; s_axis_tready is registered.
  - Next-cycle ready = m_axis_tready OR (temp empty AND (output empty OR s_axis_tvalid=0)).
  - Accepted beat with output empty or draining this cycle: loads the output register.
  - Accepted beat with output stalled: loads the temp register.
  - When the output drains and temp is full: temp moves to the output register in the same cycle.
  - Latency 1 cycle; sustained throughput 1 beat/cycle.
  - No combinational path from m_axis_tready to s_axis_tready.
- Reset (rst=0 at a clock edge, REG_TYPE 1/2):
  - m_axis_tvalid=0, temp valid=0, s_axis_tready=0.
  - Data, keep, last, id, dest and user registers are not reset; their values are don't-care while m_axis_tvalid=0.
  - First cycle after rst returns to 1: s_axis_tready=1.
  - Reset mid-stream discards buffered beats.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, all m_* outputs hold constant.
- Simultaneous input accept and output drain in skid mode: no bubble, and the temp register stays empty.

Test Plan:
- Reset then idle: after release s_axis_tready=1 on the next cycle; m_axis_tvalid stays 0.
- Streaming, REG_TYPE 2: m_axis_tready=1, send tdata 0x01..0x10 back-to-back → same sequence out, each beat exactly 1 cycle later, no gaps.
- Backpressure, REG_TYPE 2: drop m_axis_tready for 3 cycles mid-stream.
  - At most 2 beats are buffered.
  - s_axis_tready falls 1 cycle after the stall begins.
  - Output holds; the sequence resumes intact with no loss or duplication.
- REG_TYPE 1 stream of 8 beats with m_axis_tready=1 → output valid every other cycle; all 8 beats delivered in order.
- REG_TYPE 0: random s_* stimulus → m_* equal to inputs in the same cycle; s_axis_tready equals m_axis_tready.
- Sideband and reset:
  - DATA_WIDTH=16, ID_ENABLE=1: tkeep=2'b01, tlast=1, tid=0x5A passed through unchanged.
  - With KEEP_ENABLE=0, m_axis_tkeep=2'b11.
  - Reset asserted with 2 beats buffered → m_axis_tvalid=0 after the edge and no stale beat appears afterwards.
